seven_seg_scan_ctrl: RTL and testbench
======================================

SEVEN_SEG_SCAN_CTRL -- requirements
Module: seven_seg_scan_ctrl

Interface
REQ-001 Parameter NUM_DIGITS, default 8, number of multiplexed hex digits, legal range 1..8.
REQ-002 Parameter DIV, default 50000, clock cycles each digit is driven, legal range 1..2^20.
REQ-003 Parameter DEAD, default 16, all-off cycles after each digit (anti-ghosting), legal range 0..255.
REQ-004 clk  input  1  single clock; all state updates on its rising edge.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 enable  input  1  1 = scan the display; 0 = display dark.
REQ-007 load  input  1  one-cycle request to capture value.
REQ-008 value  input  32  hex word to display; nibble k is shown on digit k.
REQ-009 blank_lz  input  1  1 = blank leading-zero digits.
REQ-010 load_ack  output  1  registered one-cycle acknowledge of load.
REQ-011 digit_sel  output  NUM_DIGITS  active-low one-hot digit enable; bit k low = digit k lit.
REQ-012 seg  output  7  active-low segment pattern, bit order {g,f,e,d,c,b,a}.
REQ-013 frame_done  output  1  one-cycle pulse at the end of each complete scan.

Function
REQ-014 The block SHALL contain exactly one 4-bit-to-7-segment decoder, shared across all digits by time multiplexing, with this map: 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000, A=0001000, B=0000011, C=1000110, D=0100001, E=0000110, F=0001110.
REQ-015 The block SHALL keep a shown register, which drives the display, and a pending register, which holds the last accepted load.
REQ-016 FSM states SHALL be OFF, DRIVE and DEAD; digit index idx runs 0..NUM_DIGITS-1; prescaler cnt counts cycles within the current state.
REQ-017 OFF: digit_sel is all ones and seg is 1111111; when enable=1, the next state SHALL be DRIVE with idx=0 and cnt=0.
REQ-018 DRIVE: digit_sel bit idx SHALL be low and seg SHALL be the decoded nibble idx of shown; after DIV cycles the FSM SHALL go to DEAD, or directly to the next digit if DEAD=0.
REQ-019 DEAD: all outputs dark for DEAD cycles, then DRIVE of idx+1; after idx=NUM_DIGITS-1, idx SHALL wrap to 0.
REQ-020 Frame boundary (the last cycle of the last digit, including its dead time): frame_done SHALL pulse high in the following cycle, and shown<=pending if a load is outstanding.
REQ-021 Frame period SHALL be NUM_DIGITS*(DIV+DEAD) cycles.
REQ-022 load=1 on an edge SHALL capture value into pending and raise load_ack for exactly the next cycle.
REQ-023 Back-to-back loads SHALL each be acked; the last load before a frame boundary wins.
REQ-024 In OFF, or with enable=0, a load SHALL also update shown on the same edge.
REQ-025 A load coincident with a frame boundary SHALL be the value committed at that boundary.
REQ-026 Leading-zero blanking: when blank_lz=1, digit k>0 SHALL output seg=1111111 (digit_sel still low) if nibbles k..NUM_DIGITS-1 of shown are all zero; digit 0 is never blanked.
REQ-027 enable falling in any state SHALL force OFF on the next edge: outputs dark, idx=0, cnt=0, no frame_done, pending retained.
REQ-028 digit_sel, seg, load_ack and frame_done SHALL be registered, with no combinational path from inputs to outputs.

Reset
REQ-029 reset=1 SHALL force state=OFF, idx=0, cnt=0, shown=0, pending=0, no load outstanding, digit_sel all ones, seg=1111111, load_ack=0, frame_done=0, in the cycle after the edge, regardless of state.
REQ-030 reset SHALL take priority over load and enable on the same edge.

Verification (bench: NUM_DIGITS=4, DIV=4, DEAD=1 unless noted)
REQ-031 Reset mid-DRIVE of digit 2 -> next cycle digit_sel=1111, seg=1111111, load_ack=0; after release with enable=1, digit 0 is driven first, showing seg 1000000.
REQ-032 load value=0x0000_1A3F, enable=1, blank_lz=0 -> digit0 0001110, digit1 0110000, digit2 0001000, digit3 1111001, each low for 4 cycles, then 1 dark cycle; frame_done every 20 cycles.
REQ-033 blank_lz=1, value=0x0000_00A0 -> digit0 1000000, digit1 0001000, digits2-3 1111111; value=0 -> only digit0 shows 1000000.
REQ-034 Loads of 0x5 then 0x6 mid-frame -> two load_ack pulses; display unchanged until frame_done; the next frame shows 6 on digit0.
REQ-035 enable dropped during DEAD after digit1 -> dark the next cycle, no frame_done; re-enable -> scan restarts at digit0.
REQ-036 NUM_DIGITS=8, DEAD=0 -> no dark cycles between digits; frame_done every 32 cycles.

Source files
------------

// File: rtl/seven_seg_scan_ctrl.sv
// rtl/seven_seg_scan_ctrl.sv - multiplexed hex seven-segment scan controller
//
// Scans NUM_DIGITS hex digits through one shared segment decoder. Each digit
// is driven for DIV cycles and followed by DEAD all-off cycles. New values are
// staged in a pending register and committed at frame boundaries, or applied
// at once while the display is off or disabled.
//
// Ports:
//   clk        in   clock, rising edge
//   reset      in   synchronous active-high reset
//   enable     in   1 = scan, 0 = dark
//   load       in   capture value on this edge
//   value      in   [31:0] hex word, nibble k -> digit k
//   blank_lz   in   blank leading-zero digits (digit 0 never blanked)
//   load_ack   out  one-cycle acknowledge of load
//   digit_sel  out  [NUM_DIGITS-1:0] active-low one-hot digit enable
//   seg        out  [6:0] active-low segments {g,f,e,d,c,b,a}
//   frame_done out  one-cycle pulse after each complete scan

module seven_seg_scan_ctrl #(
    parameter int NUM_DIGITS = 8,
    parameter int DIV        = 50000,
    parameter int DEAD       = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  enable,
    input  logic                  load,
    input  logic [31:0]           value,
    input  logic                  blank_lz,
    output logic                  load_ack,
    output logic [NUM_DIGITS-1:0] digit_sel,
    output logic [6:0]            seg,
    output logic                  frame_done
);

    localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int CW = 20;
    localparam int VW = 4 * NUM_DIGITS;

    localparam logic [CW-1:0] DIV_LAST  = CW'(DIV - 1);
    localparam logic [CW-1:0] DEAD_LAST = CW'((DEAD > 0) ? DEAD - 1 : 0);
    localparam logic [IW-1:0] IDX_LAST  = IW'(NUM_DIGITS - 1);

    typedef enum logic [1:0] {
        S_OFF,
        S_DRIVE,
        S_DEAD
    } state_t;

    state_t          state, state_n;
    logic [IW-1:0]   idx, idx_n;
    logic [CW-1:0]   cnt, cnt_n;
    logic            boundary;

    logic [VW-1:0]   shown, shown_n;
    logic [VW-1:0]   pending, pending_n;
    logic            pend_valid, pend_valid_n;

    logic [NUM_DIGITS-1:0] lz;
    logic                  zero_run;
    logic [3:0]            nib;
    logic                  blank;
    logic [6:0]            dec_seg;

    logic [NUM_DIGITS-1:0] digit_sel_d;
    logic [6:0]            seg_d;

    if (VW < 32) begin : g_unused
        logic unused_value_hi;
        assign unused_value_hi = ^value[31:VW];
    end

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= S_OFF;
            idx   <= '0;
            cnt   <= '0;
        end else begin
            state <= state_n;
            idx   <= idx_n;
            cnt   <= cnt_n;
        end
    end

    // Next-state logic; boundary marks the final cycle of the last digit
    always_comb begin
        state_n  = state;
        idx_n    = idx;
        cnt_n    = cnt;
        boundary = 1'b0;
        if (!enable) begin
            state_n = S_OFF;
            idx_n   = '0;
            cnt_n   = '0;
        end else begin
            case (state)
                S_OFF: begin
                    state_n = S_DRIVE;
                    idx_n   = '0;
                    cnt_n   = '0;
                end
                S_DRIVE: begin
                    if (cnt == DIV_LAST) begin
                        cnt_n = '0;
                        if (DEAD == 0) begin
                            idx_n    = (idx == IDX_LAST) ? '0 : idx + 1'b1;
                            boundary = (idx == IDX_LAST);
                        end else begin
                            state_n = S_DEAD;
                        end
                    end else begin
                        cnt_n = cnt + 1'b1;
                    end
                end
                S_DEAD: begin
                    if (cnt == DEAD_LAST) begin
                        cnt_n    = '0;
                        state_n  = S_DRIVE;
                        idx_n    = (idx == IDX_LAST) ? '0 : idx + 1'b1;
                        boundary = (idx == IDX_LAST);
                    end else begin
                        cnt_n = cnt + 1'b1;
                    end
                end
                default: begin
                    state_n = S_OFF;
                    idx_n   = '0;
                    cnt_n   = '0;
                end
            endcase
        end
    end

    // Value staging: a load while dark, or on the boundary edge itself,
    // goes straight to shown so it is what the next frame displays.
    always_comb begin
        shown_n      = shown;
        pending_n    = pending;
        pend_valid_n = pend_valid;
        if (load) begin
            pending_n    = value[VW-1:0];
            pend_valid_n = 1'b1;
            if (state == S_OFF || !enable || boundary) begin
                shown_n      = value[VW-1:0];
                pend_valid_n = 1'b0;
            end
        end else if (boundary && pend_valid) begin
            shown_n      = pending;
            pend_valid_n = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            shown      <= '0;
            pending    <= '0;
            pend_valid <= 1'b0;
        end else begin
            shown      <= shown_n;
            pending    <= pending_n;
            pend_valid <= pend_valid_n;
        end
    end

    // lz[k] is set when nibbles k..NUM_DIGITS-1 of the next shown are all zero
    always_comb begin
        lz       = '0;
        zero_run = 1'b1;
        for (int k = NUM_DIGITS - 1; k >= 0; k--) begin
            zero_run = zero_run && (shown_n[4*k +: 4] == 4'h0);
            lz[k]    = zero_run;
        end
    end

    // Nibble select and blanking for the digit about to be driven
    always_comb begin
        nib   = 4'h0;
        blank = 1'b0;
        for (int k = 0; k < NUM_DIGITS; k++) begin
            if (idx_n == IW'(k)) begin
                nib = shown_n[4*k +: 4];
                if (k > 0) begin
                    blank = blank_lz && lz[k];
                end
            end
        end
    end

    // The single shared hex decoder
    always_comb begin
        case (nib)
            4'h0:    dec_seg = 7'b1000000;
            4'h1:    dec_seg = 7'b1111001;
            4'h2:    dec_seg = 7'b0100100;
            4'h3:    dec_seg = 7'b0110000;
            4'h4:    dec_seg = 7'b0011001;
            4'h5:    dec_seg = 7'b0010010;
            4'h6:    dec_seg = 7'b0000010;
            4'h7:    dec_seg = 7'b1111000;
            4'h8:    dec_seg = 7'b0000000;
            4'h9:    dec_seg = 7'b0010000;
            4'hA:    dec_seg = 7'b0001000;
            4'hB:    dec_seg = 7'b0000011;
            4'hC:    dec_seg = 7'b1000110;
            4'hD:    dec_seg = 7'b0100001;
            4'hE:    dec_seg = 7'b0000110;
            default: dec_seg = 7'b0001110;
        endcase
    end

    // Output logic: computed from next-state values so the registered
    // outputs line up with the state register in the same cycle.
    always_comb begin
        digit_sel_d = '1;
        seg_d       = 7'b1111111;
        if (state_n == S_DRIVE) begin
            for (int k = 0; k < NUM_DIGITS; k++) begin
                if (idx_n == IW'(k)) begin
                    digit_sel_d[k] = 1'b0;
                end
            end
            seg_d = blank ? 7'b1111111 : dec_seg;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            digit_sel  <= '1;
            seg        <= 7'b1111111;
            load_ack   <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            digit_sel  <= digit_sel_d;
            seg        <= seg_d;
            load_ack   <= load;
            frame_done <= boundary;
        end
    end

endmodule

// File: tb/tb_seven_seg_scan_ctrl.sv
// tb/tb_seven_seg_scan_ctrl.sv - self-checking bench for seven_seg_scan_ctrl

module tb_seven_seg_scan_ctrl;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset, enable, load, blank_lz;
    logic [31:0] value;
    logic        load_ack, frame_done;
    logic [3:0]  digit_sel;
    logic [6:0]  seg;

    logic        reset8, enable8, load8, blank_lz8;
    logic [31:0] value8;
    logic        load_ack8, frame_done8;
    logic [7:0]  digit_sel8;
    logic [6:0]  seg8;

    int checks = 0;
    int errors = 0;

    seven_seg_scan_ctrl #(.NUM_DIGITS(4), .DIV(4), .DEAD(1)) dut (
        .clk        (clk),
        .reset      (reset),
        .enable     (enable),
        .load       (load),
        .value      (value),
        .blank_lz   (blank_lz),
        .load_ack   (load_ack),
        .digit_sel  (digit_sel),
        .seg        (seg),
        .frame_done (frame_done)
    );

    seven_seg_scan_ctrl #(.NUM_DIGITS(8), .DIV(4), .DEAD(0)) dut8 (
        .clk        (clk),
        .reset      (reset8),
        .enable     (enable8),
        .load       (load8),
        .value      (value8),
        .blank_lz   (blank_lz8),
        .load_ack   (load_ack8),
        .digit_sel  (digit_sel8),
        .seg        (seg8),
        .frame_done (frame_done8)
    );

    typedef struct packed {
        logic [31:0] value;
        logic        blz;
        logic [27:0] segs;   // {digit3, digit2, digit1, digit0}
    } vec_t;

    vec_t vecs [8];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Called at cycle 0 of a frame; returns at cycle 0 of the next frame.
    task automatic check_frame(input string name, input logic [27:0] segs, input logic first_fd);
        logic [3:0] es;
        logic [6:0] eg;
        for (int c = 0; c < 20; c++) begin
            int d;
            d = c / 5;
            if ((c % 5) < 4) begin
                es = ~(4'b0001 << d);
                eg = segs[7*d +: 7];
            end else begin
                es = 4'hF;
                eg = 7'h7F;
            end
            check($sformatf("%s c%0d {sel,seg,fd,ack}", name, c),
                  {19'd0, digit_sel, seg, frame_done, load_ack},
                  {19'd0, es, eg, (c == 0) ? first_fd : 1'b0, 1'b0});
            tick();
        end
        check($sformatf("%s frame_done", name), {31'd0, frame_done}, 32'd1);
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    logic [6:0] hex8 [8];
    int         bad;

    initial begin
        vecs[0] = '{32'h0000_1A3F, 1'b0, {7'b1111001, 7'b0001000, 7'b0110000, 7'b0001110}};
        vecs[1] = '{32'h0000_00A0, 1'b1, {7'b1111111, 7'b1111111, 7'b0001000, 7'b1000000}};
        vecs[2] = '{32'h0000_0000, 1'b1, {7'b1111111, 7'b1111111, 7'b1111111, 7'b1000000}};
        vecs[3] = '{32'h0000_0000, 1'b0, {7'b1000000, 7'b1000000, 7'b1000000, 7'b1000000}};
        vecs[4] = '{32'h0000_B7C0, 1'b1, {7'b0000011, 7'b1111000, 7'b1000110, 7'b1000000}};
        vecs[5] = '{32'h0000_8D06, 1'b1, {7'b0000000, 7'b0100001, 7'b1000000, 7'b0000010}};
        vecs[6] = '{32'h0000_2E49, 1'b0, {7'b0100100, 7'b0000110, 7'b0011001, 7'b0010000}};
        vecs[7] = '{32'hABCD_5000, 1'b1, {7'b0010010, 7'b1000000, 7'b1000000, 7'b1000000}};
        hex8 = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
                 7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000};

        reset = 1'b1; enable = 1'b0; load = 1'b0; blank_lz = 1'b0; value = '0;
        reset8 = 1'b1; enable8 = 1'b0; load8 = 1'b0; blank_lz8 = 1'b0; value8 = '0;
        #1;
        run(2);
        check("reset digit_sel", {28'd0, digit_sel}, 32'hF);
        check("reset seg", {25'd0, seg}, 32'h7F);
        check("reset load_ack", {31'd0, load_ack}, 32'd0);
        check("reset frame_done", {31'd0, frame_done}, 32'd0);
        reset = 1'b0;
        reset8 = 1'b0;

        // Table: load while disabled (applies at once), then scan one frame
        for (int i = 0; i < 8; i++) begin
            enable   = 1'b0;
            blank_lz = vecs[i].blz;
            value    = vecs[i].value;
            load     = 1'b1;
            tick();
            check($sformatf("vec%0d load_ack", i), {31'd0, load_ack}, 32'd1);
            check($sformatf("vec%0d dark while off", i), {21'd0, digit_sel, seg}, {21'd0, 4'hF, 7'h7F});
            load   = 1'b0;
            enable = 1'b1;
            tick();
            check_frame($sformatf("vec%0d", i), vecs[i].segs, 1'b0);
        end
        // One more frame of the last vector: frame_done every 20 cycles
        check_frame("vec7 frame2", vecs[7].segs, 1'b1);

        // Back-to-back loads mid-frame are staged until the boundary
        enable = 1'b0; blank_lz = 1'b0; value = 32'h0000_1113; load = 1'b1;
        tick();
        load = 1'b0; enable = 1'b1;
        tick();                                  // cycle 0
        check("stage d0 before", {25'd0, seg}, {25'd0, 7'b0110000});
        value = 32'h5; load = 1'b1;
        tick();                                  // cycle 1
        check("stage ack1", {31'd0, load_ack}, 32'd1);
        value = 32'h6;
        tick();                                  // cycle 2
        check("stage ack2", {31'd0, load_ack}, 32'd1);
        load = 1'b0;
        tick();                                  // cycle 3
        check("stage ack3", {31'd0, load_ack}, 32'd0);
        run(4);                                  // cycle 7
        check("stage d1 unchanged", {21'd0, digit_sel, seg}, {21'd0, 4'b1101, 7'b1111001});
        run(10);                                 // cycle 17
        check("stage d3 unchanged", {21'd0, digit_sel, seg}, {21'd0, 4'b0111, 7'b1111001});
        run(3);                                  // cycle 20
        check("stage commit", {20'd0, digit_sel, seg, frame_done}, {20'd0, 4'b1110, 7'b0000010, 1'b1});
        run(5);                                  // cycle 25
        check("stage d1 now 0", {21'd0, digit_sel, seg}, {21'd0, 4'b1101, 7'b1000000});

        // Load on the boundary edge is the value committed there
        run(14);                                 // cycle 39, last dead cycle
        value = 32'h7; load = 1'b1;
        tick();                                  // cycle 40
        load = 1'b0;
        check("boundary load", {19'd0, digit_sel, seg, frame_done, load_ack},
              {19'd0, 4'b1110, 7'b1111000, 1'b1, 1'b1});

        // Enable dropped during the dead time after digit 1
        run(9);                                  // dead after digit 1
        check("dead after d1", {21'd0, digit_sel, seg}, {21'd0, 4'hF, 7'h7F});
        enable = 1'b0;
        bad = 0;
        for (int c = 0; c < 25; c++) begin
            tick();
            if (digit_sel !== 4'hF || seg !== 7'h7F || frame_done !== 1'b0) bad++;
        end
        check("disabled stays dark", bad, 0);
        enable = 1'b1;
        tick();
        check("re-enable digit0", {21'd0, digit_sel, seg}, {21'd0, 4'b1110, 7'b1111000});

        // Reset mid-drive of digit 2 wins over load and enable
        run(11);
        check("pre-reset digit2", {28'd0, digit_sel}, 32'b1011);
        reset = 1'b1; load = 1'b1; value = 32'h0000_1A3F;
        tick();
        check("reset mid-drive", {20'd0, digit_sel, seg, load_ack}, {20'd0, 4'hF, 7'h7F, 1'b0});
        reset = 1'b0; load = 1'b0;
        tick();
        check("after reset digit0", {20'd0, digit_sel, seg, frame_done}, {20'd0, 4'b1110, 7'b1000000, 1'b0});
        run(20);
        check("after reset no stale commit", {20'd0, digit_sel, seg, frame_done},
              {20'd0, 4'b1110, 7'b1000000, 1'b1});

        // Eight digits with no dead time
        value8 = 32'h7654_3210; load8 = 1'b1;
        tick();
        load8 = 1'b0; enable8 = 1'b1;
        tick();
        bad = 0;
        for (int c = 0; c < 64; c++) begin
            int d;
            d = (c / 4) % 8;
            if (digit_sel8 !== ~(8'b1 << d) || seg8 !== hex8[d] || frame_done8 !== (c == 32)) begin
                bad++;
                if (bad == 1)
                    $display("FAIL dead0 c%0d: got sel=%b seg=%b fd=%b", c, digit_sel8, seg8, frame_done8);
            end
            tick();
        end
        check("dead0 scan cycles", bad, 0);
        check("dead0 frame_done at 64", {31'd0, frame_done8}, 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
